// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the requester that was not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = GNT_IF;
    if (req[GNT_D] && req[GNT_IF]) begin
      gnt = ~last;
    end else if (req[GNT_D]) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and data ports,
// one transaction at a time, with round-robin arbitration on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_sel,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_sel,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_sel_q, mem_sel_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic              arb_gnt;
  logic              arb_valid;

  rr_arb2 u_rr_arb2 (
    .req   ({d_req, if_req}),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d    = arb_gnt;
          last_d   = arb_gnt;
          mem_ce_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
          if (arb_gnt == GNT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_sel_d   = d_sel;
          end else begin
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_sel_d   = '1;
          end
        end
      end
      ISSUE: begin
        // mem_we_q is only ever high in ISSUE, so it doubles as the write flag
        if (mem_we_q) begin
          if_ack_d = (gnt_q == GNT_IF);
          d_ack_d  = (gnt_q == GNT_D);
          state_d  = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (gnt_q == GNT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          if_ack_d = (gnt_q == GNT_IF);
          d_ack_d  = (gnt_q == GNT_D);
          state_d  = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GNT_IF;
      gnt_q       <= GNT_IF;
      cnt_q       <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel   = mem_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        busy;

  logic        if_req3 = 1'b0;
  logic [31:0] if_addr3 = '0;
  logic        if_ack3;
  logic [31:0] if_rdata3;
  logic        d_req3 = 1'b0;
  logic        d_we3 = 1'b0;
  logic [31:0] d_addr3 = '0;
  logic [31:0] d_wdata3 = '0;
  logic [3:0]  d_sel3 = '0;
  logic        d_ack3;
  logic [31:0] d_rdata3;
  logic        mem_ce3, mem_we3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_sel3;
  logic        busy3;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_sel(d_sel3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_ce(mem_ce3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_sel(mem_sel3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h3401_1100 : ((a ^ 32'hA5A5_0000) + 32'h0000_1111);
  endfunction

  // Memory models: data appears MEM_LAT cycles after the edge that samples mem_ce,
  // for exactly one cycle, so a capture in the wrong cycle sees zero.
  logic [31:0] rd1_q = '0;
  logic [31:0] p0_q = '0, p1_q = '0, p2_q = '0;
  always @(posedge clk) begin
    rd1_q <= (mem_ce && !mem_we) ? mem_word(mem_addr) : 32'h0;
    p0_q  <= (mem_ce3 && !mem_we3) ? mem_word(mem_addr3) : 32'h0;
    p1_q  <= p0_q;
    p2_q  <= p1_q;
  end
  assign mem_rdata  = rd1_q;
  assign mem_rdata3 = p2_q;

  // Requesters must hold req until they have seen ack; acks are mutually exclusive.
  logic ifr_p = 1'b0, ifa_p = 1'b0, dr_p = 1'b0, da_p = 1'b0, if3r_p = 1'b0, if3a_p = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      ifr_p <= 1'b0; ifa_p <= 1'b0; dr_p <= 1'b0; da_p <= 1'b0; if3r_p <= 1'b0; if3a_p <= 1'b0;
    end else begin
      assert (!(ifr_p && !if_req && !ifa_p)) else $error("protocol violation: if_req dropped before if_ack");
      assert (!(dr_p && !d_req && !da_p)) else $error("protocol violation: d_req dropped before d_ack");
      assert (!(if3r_p && !if_req3 && !if3a_p)) else $error("protocol violation: if_req3 dropped before if_ack3");
      assert (!(if_ack && d_ack)) else $error("protocol violation: if_ack and d_ack together");
      ifr_p <= if_req; ifa_p <= if_ack; dr_p <= d_req; da_p <= d_ack;
      if3r_p <= if_req3; if3a_p <= if_ack3;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ifv, dv, cev;
    logic [31:0] addrs [3];
    logic [31:0] d_rd_before;
    logic        ackd, any_ack;
    int unsigned nce, nack;

    // Reset state
    tick(); tick();
    chk("rst_ctrl", {busy, mem_ce, mem_we, if_ack, d_ack}, 5'b0);
    chk("rst_addr_sel", {mem_addr, mem_sel}, 36'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    rst = 1'b0;

    // Tie straight after reset: D first, then alternating while both are held
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_sel = 4'hF;
    ifv = '0; dv = '0; cev = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      ifv[k] = if_ack; dv[k] = d_ack; cev[k] = mem_ce;
      if (k == 1) chk("tie_first_addr", mem_addr, 32'h20);
      if (k == 5) chk("tie_second_addr", mem_addr, 32'h0);
      if (k == 3) chk("tie_d_rdata", d_rdata, mem_word(32'h20));
      if (k == 7) chk("tie_if_rdata", if_rdata, mem_word(32'h0));
      if (k == 12) d_req = 1'b0;
    end
    chk("tie_d_acks", dv, 16'h0808);
    chk("tie_if_acks", ifv, 16'h8080);
    chk("tie_ce", cev, 16'h2222);
    tick();
    if_req = 1'b0;
    tick(); tick();

    // Single fetch at 0x4, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h4;
    ifv = '0; cev = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ifv[k] = if_ack; cev[k] = mem_ce;
      if (k == 1) chk("fetch_issue", {mem_addr, mem_we, mem_sel}, {32'h4, 1'b0, 4'hF});
      if (k == 3) chk("fetch_rdata", if_rdata, 32'h3401_1100);
      if (k == 2) chk("fetch_busy", busy, 1'b1);
      if (k == 4) if_req = 1'b0;
    end
    chk("fetch_ack_timing", ifv, 16'h0008);
    chk("fetch_ce_once", cev, 16'h0002);
    chk("fetch_idle_busy", busy, 1'b0);

    // Data write
    d_rd_before = d_rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
    dv = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      dv[k] = d_ack;
      if (k == 1) chk("wr_issue", {mem_ce, mem_we, mem_sel, mem_addr}, {1'b1, 1'b1, 4'b0011, 32'h100});
      if (k == 1) chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (k == 2) chk("wr_rdata_kept", d_rdata, d_rd_before);
      if (k == 3) d_req = 1'b0;
    end
    chk("wr_ack_timing", dv, 16'h0004);
    d_we = 1'b0;

    // Back-to-back fetches at 0x0, 0x4, 0x8
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    if_req = 1'b1; if_addr = addrs[0];
    ifv = '0; nce = 0; nack = 0; ackd = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      ifv[k] = if_ack;
      if (mem_ce) begin
        if (nce < 3) chk("b2b_addr", mem_addr, addrs[nce]);
        else chk("b2b_extra_issue", mem_ce, 1'b0);
        nce++;
      end
      if (if_ack) begin
        if (nack < 3) chk("b2b_rdata", if_rdata, mem_word(addrs[nack]));
        else chk("b2b_extra_ack", if_ack, 1'b0);
        nack++;
      end
      if (ackd) begin
        if (nack < 3) if_addr = addrs[nack];
        else if_req = 1'b0;
      end
      ackd = if_ack;
    end
    chk("b2b_ack_timing", ifv, 16'h0888);
    chk("b2b_counts", {nce[7:0], nack[7:0]}, {8'd3, 8'd3});

    // Reset during WAIT abandons the fetch
    if_req = 1'b1; if_addr = 32'hC;
    tick(); tick();
    chk("rstmid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_async", {busy, mem_ce, if_ack}, 3'b000);
    if_req = 1'b0;
    any_ack = 1'b0;
    tick();
    chk("rstmid_edge", {busy, mem_ce}, 2'b00);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      any_ack = any_ack | if_ack | d_ack;
    end
    chk("rstmid_no_ack", any_ack, 1'b0);

    // MEM_LAT=3 read at 0x8
    if_req3 = 1'b1; if_addr3 = 32'h8;
    ifv = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ifv[k] = if_ack3;
      if (k == 5) chk("lat3_rdata", if_rdata3, mem_word(32'h8));
      if (k == 6) if_req3 = 1'b0;
    end
    chk("lat3_ack_timing", ifv, 16'h0020);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Sits between the openmips core and the unified memory in the minimal SOPC.
- Runs one transaction at a time using a req/ack handshake per requester.
- Uses round-robin arbitration when both requesters are pending.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- MEM_LAT, 1, read latency in cycles of the memory, counted from the cycle it samples mem_ce; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req=1.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DW  fetch data, valid when if_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_sel  in  DW/8  byte enables.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DW  read data, valid when d_ack=1.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_sel  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all ack, mem_ce, mem_we, busy = 0.
  - mem_addr, mem_wdata, mem_sel, if_rdata, d_rdata = 0.
  - last_grant=IF, so the first tie goes to D.
  - A reset mid-transaction abandons it; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On grant, register addr/we/wdata/sel into the mem_* outputs, update last_grant, go to ISSUE.
  - Fetch requests always set mem_we=0 and mem_sel all-ones.
- ISSUE (1 cycle):
  - mem_ce=1, with mem_we as registered.
  - Write: go to RESP.
  - Read: load cnt=MEM_LAT-1, go to WAIT.
- WAIT:
  - mem_ce=0, mem_we=0.
  - cnt!=0: decrement.
  - cnt==0: capture mem_rdata into the granted requester's rdata register, go to RESP.
- RESP (1 cycle):
  - Assert the ack of the granted port only; go to IDLE.
  - rdata registers hold their value until the next capture.
  - A write ack leaves d_rdata unchanged.
- Latency from req first high in IDLE to ack:
  - Write: 2 cycles.
  - Read: MEM_LAT+2 cycles (3 when MEM_LAT=1).
- Back-to-back traffic:
  - A requester keeping req high after ack is re-sampled in the IDLE cycle after RESP.
  - Minimum spacing is one IDLE cycle between transactions.
- Requests arriving outside IDLE wait; they are not lost, because the requester must hold req.
- A requester dropping req before ack is a protocol violation; the behaviour is undefined and a bench assertion must flag it.
- if_ack and d_ack are never high in the same cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - The state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - The grant IDs GNT_IF=1'b0 and GNT_D=1'b1.
  - The default AW, DW and MEM_LAT constants.
- One natural sub-module: rr_arb2.
  - Two-input round-robin picker: inputs req[1:0] and last; outputs gnt and valid.
  - Purely combinational; the last_grant register stays in the parent.

Test Plan:
- Reset mid-read: assert rst during WAIT -> on the next clock edge state=IDLE, mem_ce=0, no if_ack ever pulses, busy=0.
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x0000_0004; memory returns 0x3401_1100; MEM_LAT=1.
  - Response: mem_ce high for exactly 1 cycle with mem_addr=0x4 and mem_we=0; if_ack high for 1 cycle, 3 cycles after req; if_rdata=0x3401_1100.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_sel=4'b0011.
  - Response: mem_we=1 and mem_sel=4'b0011 in the ISSUE cycle; d_ack 2 cycles after req; d_rdata unchanged.
- Simultaneous requests straight after reset: if_req=d_req=1 -> D is served first, then IF on the next IDLE. With both held continuously, acks alternate D, IF, D, IF.
- MEM_LAT=3 read at 0x8 -> if_ack arrives 5 cycles after req, with the data the memory presented 3 cycles after the ISSUE cycle.
- Continuous back-to-back fetches at 0x0, 0x4, 0x8 (MEM_LAT=1) -> acks every 4 cycles, addresses in order, no duplicated or skipped ack.
